// File: rtl/vport_stream_rx.sv
// Parallel video port receiver: registers RGB/HS/VS/DE, measures frame geometry and
// streams {start, rgb} words through a first-word-fall-through FIFO with backpressure.
module vport_stream_rx #(
   parameter int H_BITS     = 12,
   parameter int V_BITS     = 12,
   parameter int FIFO_DEPTH = 16,
   parameter bit HS_POL     = 1'b1,
   parameter bit VS_POL     = 1'b1
) (
   input  logic              iCLK,
   input  logic              iRESET,
   input  logic [7:0]        iRED,
   input  logic [7:0]        iGRN,
   input  logic [7:0]        iBLU,
   input  logic              iHS,
   input  logic              iVS,
   input  logic              iDE,
   output logic [23:0]       oDATA,
   output logic              oDV,
   output logic              oSTART,
   input  logic              iREADY,
   output logic [H_BITS-1:0] oWIDTH,
   output logic [V_BITS-1:0] oHEIGHT,
   output logic              oLOCKED,
   output logic [1:0]        oERR,
   input  logic              iERR_CLR
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_WAIT_VS, S_ACTIVE, S_DROP} state_t;

   logic [23:0]       r_rgb_p0;
   logic              r_de_p0, r_vs_act_p0, r_hs_act_p0;
   logic              r_de_p1, r_vs_act_p1;
   logic              w_hs_unused;
   logic              w_fb, w_le;

   state_t            r_state;
   logic              r_sof;

   logic [24:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [AW:0]       r_count;
   logic [24:0]       w_head;
   logic              w_empty, w_full, w_pop, w_push_req, w_push, w_ovf;

   logic [H_BITS-1:0] r_pix_cnt, r_first_w, r_width;
   logic [V_BITS-1:0] r_line_cnt, r_height;
   logic              r_locked;
   logic [1:0]        r_err;
   logic              w_len_err;

   // Stage p0: port registers, sync polarity normalised to active-high
   always_ff @(posedge iCLK) begin
      r_rgb_p0 <= {iRED, iGRN, iBLU};
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_de_p0     <= 1'b0;
         r_vs_act_p0 <= 1'b0;
         r_hs_act_p0 <= 1'b0;
         r_de_p1     <= 1'b0;
         r_vs_act_p1 <= 1'b0;
      end else begin
         r_de_p0     <= iDE;
         r_vs_act_p0 <= (iVS == VS_POL);
         r_hs_act_p0 <= (iHS == HS_POL);
         r_de_p1     <= r_de_p0;
         r_vs_act_p1 <= r_vs_act_p0;
      end
   end

   // Line boundaries come from DE alone; normalised HS has no consumer here.
   assign w_hs_unused = r_hs_act_p0;
   assign w_fb        = r_vs_act_p0 && !r_vs_act_p1;
   assign w_le        = r_de_p1 && !r_de_p0;

   // Stage p1: FIFO write side and frame-capture state machine
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_pop      = !w_empty && iREADY;
   assign w_push_req = (r_state == S_ACTIVE) && r_de_p0;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovf      = w_push_req && w_full && !w_pop;

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_state <= S_WAIT_VS;
         r_sof   <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT_VS, S_DROP: begin
               if (w_fb) begin
                  r_state <= S_ACTIVE;
                  r_sof   <= 1'b1;
               end
            end
            S_ACTIVE: begin
               if (w_ovf) r_state <= S_DROP;
               if (w_fb)        r_sof <= 1'b1;
               else if (w_push) r_sof <= 1'b0;
            end
            default: r_state <= S_WAIT_VS;
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      if (w_push) r_mem[r_wr_ptr] <= {r_sof, r_rgb_p0};
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Read side falls through: the head entry is visible as soon as it is written.
   assign w_head = r_mem[r_rd_ptr];
   assign oDV    = !w_empty;
   assign oDATA  = w_empty ? 24'h0 : w_head[23:0];
   assign oSTART = !w_empty && w_head[24];

   // Geometry measurement runs regardless of capture state
   assign w_len_err = w_le && (r_line_cnt != '0) && (r_pix_cnt != r_first_w);

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_pix_cnt  <= '0;
         r_first_w  <= '0;
         r_line_cnt <= '0;
         r_width    <= '0;
         r_height   <= '0;
         r_locked   <= 1'b0;
         r_err      <= 2'b00;
      end else begin
         if (w_le)                             r_pix_cnt <= '0;
         else if (r_de_p0 && r_pix_cnt != '1) r_pix_cnt <= r_pix_cnt + H_BITS'(1);
         if (w_le && r_line_cnt == '0) r_first_w <= r_pix_cnt;
         if (w_fb) begin
            if (r_line_cnt != '0) begin
               r_width  <= r_first_w;
               r_height <= r_line_cnt;
               r_locked <= (r_first_w == r_width) && (r_line_cnt == r_height);
            end
            r_line_cnt <= '0;
         end else if (w_le && r_line_cnt != '1) begin
            r_line_cnt <= r_line_cnt + V_BITS'(1);
         end
         r_err[0] <= w_len_err || (r_err[0] && !iERR_CLR);
         r_err[1] <= w_ovf     || (r_err[1] && !iERR_CLR);
      end
   end

   assign oWIDTH  = r_width;
   assign oHEIGHT = r_height;
   assign oLOCKED = r_locked;
   assign oERR    = r_err;

endmodule

// File: tb/tb_vport_stream_rx.sv
// Scoreboard bench for vport_stream_rx: one DUT with active-high syncs and one with
// inverted syncs, both fed the same video and expected to behave identically.
module tb_vport_stream_rx;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, de, hs, vs, ready, err_clr;
   logic [7:0]  red, grn, blu;
   logic [23:0] data_o   [2];
   logic        dv_o     [2];
   logic        start_o  [2];
   logic        locked_o [2];
   logic [11:0] width_o  [2];
   logic [11:0] height_o [2];
   logic [1:0]  err_o    [2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc++;

   vport_stream_rx #(.FIFO_DEPTH(DEPTH)) u_pos (
      .iCLK(clk), .iRESET(rst), .iRED(red), .iGRN(grn), .iBLU(blu),
      .iHS(hs), .iVS(vs), .iDE(de),
      .oDATA(data_o[0]), .oDV(dv_o[0]), .oSTART(start_o[0]), .iREADY(ready),
      .oWIDTH(width_o[0]), .oHEIGHT(height_o[0]), .oLOCKED(locked_o[0]),
      .oERR(err_o[0]), .iERR_CLR(err_clr));

   vport_stream_rx #(.FIFO_DEPTH(DEPTH), .HS_POL(1'b0), .VS_POL(1'b0)) u_neg (
      .iCLK(clk), .iRESET(rst), .iRED(red), .iGRN(grn), .iBLU(blu),
      .iHS(~hs), .iVS(~vs), .iDE(de),
      .oDATA(data_o[1]), .oDV(dv_o[1]), .oSTART(start_o[1]), .iREADY(ready),
      .oWIDTH(width_o[1]), .oHEIGHT(height_o[1]), .oLOCKED(locked_o[1]),
      .oERR(err_o[1]), .iERR_CLR(err_clr));

   // Reference model: capture state, start flag and one expected-word queue per DUT
   logic [24:0] q0[$];
   logic [24:0] q1[$];
   int mstate    = 0;   // 0 wait for VS, 1 active, 2 dropping
   bit m_sof     = 1'b0;
   bit m_vs_prev = 1'b0;
   bit rst_next  = 1'b1;
   int lat_watch = 0;
   int lat_start = 0;
   int pop_cnt [2];

   task automatic drive_cycle(input bit de_i, input logic [23:0] rgb_i, input bit vs_i);
      @(posedge clk); #1;
      rst = rst_next;
      de  = de_i;
      {red, grn, blu} = rgb_i;
      vs  = vs_i;
      hs  = !de_i;
      if (rst_next) begin
         mstate = 0; m_sof = 1'b0; m_vs_prev = 1'b0;
         q0.delete(); q1.delete();
      end else begin
         if (vs_i && !m_vs_prev) begin mstate = 1; m_sof = 1'b1; end
         m_vs_prev = vs_i;
         if (de_i && mstate == 1) begin
            if (!ready && q0.size() >= DEPTH) mstate = 2;
            else begin
               q0.push_back({m_sof, rgb_i});
               q1.push_back({m_sof, rgb_i});
               m_sof = 1'b0;
               if (lat_watch == 1) begin lat_watch = 2; lat_start = cyc; end
            end
         end
      end
   endtask

   // Lines of 4 pixels (line 2 may differ) + 3 blanking cycles, then a VS pulse.
   task automatic drive_frame(input int nlines, input int w_line2, input int stall_at, input int rel_at);
      int fc  = 0;
      int idx = 1;
      for (int l = 0; l < nlines; l++) begin
         int w;
         w = (l == 1) ? w_line2 : 4;
         for (int p = 0; p < w + 3; p++) begin
            if (fc == rel_at) rst_next = 1'b0;
            if (p < w) begin drive_cycle(1'b1, 24'(idx), 1'b0); idx++; end
            else drive_cycle(1'b0, 24'h0, 1'b0);
            if (stall_at >= 0 && fc == stall_at)     ready = 1'b0;
            if (stall_at >= 0 && fc == stall_at + 5) ready = 1'b1;
            fc++;
         end
      end
      for (int k = 0; k < 8; k++) drive_cycle(1'b0, 24'h0, (k >= 2 && k < 5));
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((q0.size() != 0 || q1.size() != 0 || dv_o[0] || dv_o[1]) && t < 300) begin
         drive_cycle(1'b0, 24'h0, 1'b0);
         t++;
      end
      n_tests++;
      if (t >= 300) begin
         n_fail++;
         $display("FAIL drain: %0d/%0d words still expected after %0d cycles", q0.size(), q1.size(), t);
      end
   endtask

   // Output monitor: scoreboard pops, stall stability and first-word latency
   logic [25:0] prev_o [2];
   bit          hold_o [2];
   always @(negedge clk) begin
      logic [24:0] exp_w;
      bit          have;
      for (int d = 0; d < 2; d++) begin
         if (rst) hold_o[d] = 1'b0;
         else begin
            if (hold_o[d]) begin
               n_tests++;
               if ({dv_o[d], start_o[d], data_o[d]} !== prev_o[d]) begin
                  n_fail++;
                  $display("FAIL hold dut%0d: got %h, required %h", d, {dv_o[d], start_o[d], data_o[d]}, prev_o[d]);
               end
            end
            hold_o[d] = dv_o[d] && !ready;
            prev_o[d] = {dv_o[d], start_o[d], data_o[d]};
            if (d == 0 && lat_watch == 2 && dv_o[0]) begin
               n_tests++;
               if (cyc - lat_start != 2) begin
                  n_fail++;
                  $display("FAIL latency: got %0d cycles, required 2", cyc - lat_start);
               end
               lat_watch = 0;
            end
            if (dv_o[d] && ready) begin
               have  = 1'b1;
               exp_w = '0;
               if (d == 0) begin if (q0.size() == 0) have = 1'b0; else exp_w = q0.pop_front(); end
               else        begin if (q1.size() == 0) have = 1'b0; else exp_w = q1.pop_front(); end
               pop_cnt[d]++;
               n_tests++;
               if (!have) begin
                  n_fail++;
                  $display("FAIL word dut%0d: got start=%b data=%h, required no word", d, start_o[d], data_o[d]);
               end else if ({start_o[d], data_o[d]} !== exp_w) begin
                  n_fail++;
                  $display("FAIL word dut%0d: got start=%b data=%h, required start=%b data=%h",
                           d, start_o[d], data_o[d], exp_w[24], exp_w[23:0]);
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst_next = 1'b1;
      for (int k = 0; k < 3; k++) drive_cycle(1'b0, 24'h0, 1'b0);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if ({dv_o[d], start_o[d], data_o[d], width_o[d], height_o[d], locked_o[d], err_o[d]} !== '0) begin
            n_fail++;
            $display("FAIL reset dut%0d: got dv=%b st=%b data=%h w=%0d h=%0d lock=%b err=%b, required all 0",
                     d, dv_o[d], start_o[d], data_o[d], width_o[d], height_o[d], locked_o[d], err_o[d]);
         end
      end
      rst_next = 1'b0;
      drive_cycle(1'b0, 24'h0, 1'b0);
   endtask

   task automatic test_basic();
      drive_frame(2, 4, -1, -1);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (width_o[d] !== 12'd4 || height_o[d] !== 12'd2 || locked_o[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL geom_first dut%0d: got %0dx%0d lock=%b, required 4x2 lock=0", d, width_o[d], height_o[d], locked_o[d]);
         end
      end
      lat_watch = 1;
      drive_frame(2, 4, -1, -1);
      drive_frame(2, 4, -1, -1);
      wait_drain();
      n_tests++;
      if (lat_watch != 0) begin
         n_fail++;
         $display("FAIL latency: got no oDV, required oDV 2 cycles after first pixel");
      end
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (width_o[d] !== 12'd4 || height_o[d] !== 12'd2 || locked_o[d] !== 1'b1 || err_o[d] !== 2'b00) begin
            n_fail++;
            $display("FAIL geom_lock dut%0d: got %0dx%0d lock=%b err=%b, required 4x2 lock=1 err=00",
                     d, width_o[d], height_o[d], locked_o[d], err_o[d]);
         end
      end
   endtask

   task automatic test_stall();
      drive_frame(2, 4, 1, -1);
      wait_drain();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (locked_o[d] !== 1'b1 || err_o[d] !== 2'b00) begin
            n_fail++;
            $display("FAIL stall dut%0d: got lock=%b err=%b, required lock=1 err=00", d, locked_o[d], err_o[d]);
         end
      end
   endtask

   task automatic test_overflow();
      int base [2];
      ready = 1'b0;
      drive_frame(8, 4, -1, -1);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (err_o[d] !== 2'b10 || width_o[d] !== 12'd4 || height_o[d] !== 12'd8 || locked_o[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow dut%0d: got err=%b %0dx%0d lock=%b, required err=10 4x8 lock=0",
                     d, err_o[d], width_o[d], height_o[d], locked_o[d]);
         end
         base[d] = pop_cnt[d];
      end
      ready = 1'b1;
      wait_drain();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (pop_cnt[d] - base[d] != DEPTH) begin
            n_fail++;
            $display("FAIL held_words dut%0d: got %0d, required %0d", d, pop_cnt[d] - base[d], DEPTH);
         end
      end
      drive_frame(8, 4, -1, -1);
      wait_drain();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (err_o[d] !== 2'b10 || locked_o[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL recover dut%0d: got err=%b lock=%b, required err=10 lock=1", d, err_o[d], locked_o[d]);
         end
      end
      err_clr = 1'b1;
      drive_cycle(1'b0, 24'h0, 1'b0);
      err_clr = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (err_o[d] !== 2'b00) begin
            n_fail++;
            $display("FAIL err_clr_ovf dut%0d: got %b, required 00", d, err_o[d]);
         end
      end
   endtask

   task automatic test_line_err();
      drive_frame(3, 5, -1, -1);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (err_o[d] !== 2'b01 || width_o[d] !== 12'd4 || height_o[d] !== 12'd3 || locked_o[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL line_err dut%0d: got err=%b %0dx%0d lock=%b, required err=01 4x3 lock=0",
                     d, err_o[d], width_o[d], height_o[d], locked_o[d]);
         end
      end
      err_clr = 1'b1;
      drive_cycle(1'b0, 24'h0, 1'b0);
      err_clr = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (err_o[d] !== 2'b00) begin
            n_fail++;
            $display("FAIL err_clr_len dut%0d: got %b, required 00", d, err_o[d]);
         end
      end
      drive_frame(2, 4, -1, -1);
      drive_frame(2, 4, -1, -1);
      wait_drain();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (width_o[d] !== 12'd4 || height_o[d] !== 12'd2 || locked_o[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL relock dut%0d: got %0dx%0d lock=%b, required 4x2 lock=1", d, width_o[d], height_o[d], locked_o[d]);
         end
      end
   endtask

   // Reset released on the third pixel of line 1: only pixels 3..4 are measured.
   task automatic test_reset_midframe();
      rst_next = 1'b1;
      drive_cycle(1'b0, 24'h0, 1'b0);
      drive_cycle(1'b0, 24'h0, 1'b0);
      drive_frame(2, 4, -1, 2);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (err_o[d] !== 2'b01 || width_o[d] !== 12'd2 || height_o[d] !== 12'd2 || locked_o[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe dut%0d: got err=%b %0dx%0d lock=%b, required err=01 2x2 lock=0",
                     d, err_o[d], width_o[d], height_o[d], locked_o[d]);
         end
      end
      drive_frame(2, 4, -1, -1);
      wait_drain();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (width_o[d] !== 12'd4 || height_o[d] !== 12'd2 || locked_o[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset dut%0d: got %0dx%0d lock=%b, required 4x2 lock=0", d, width_o[d], height_o[d], locked_o[d]);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; de = 1'b0; hs = 1'b1; vs = 1'b0; ready = 1'b1; err_clr = 1'b0;
      red = '0; grn = '0; blu = '0;
      pop_cnt[0] = 0; pop_cnt[1] = 0;
      test_reset();
      test_basic();
      test_stall();
      test_overflow();
      test_line_err();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
